// File: rtl/sys_array_loader_if.sv
// Stream-in / matrix-out bundle between the array loader and its host and fetcher.
// reuse_b is present only when LOADER_REUSE_B_EN is defined.
interface sys_array_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4
);
  logic                                             in_valid;
  logic [DATA_WIDTH-1:0]                            in_data;
  logic                                             in_ready;
  logic [ARRAY_W-1:0][ARRAY_L-1:0][DATA_WIDTH-1:0]  input_data_a;
  logic [ARRAY_W-1:0][ARRAY_L-1:0][DATA_WIDTH-1:0]  input_data_b;
  logic                                             load_params;
  logic                                             start_comp;
  logic                                             busy;
  logic                                             job_done;
`ifdef LOADER_REUSE_B_EN
  logic                                             reuse_b;
`endif

  modport master (
`ifdef LOADER_REUSE_B_EN
    input  reuse_b,
`endif
    input  in_valid,
    input  in_data,
    output in_ready,
    output input_data_a,
    output input_data_b,
    output load_params,
    output start_comp,
    output busy,
    output job_done
  );

  modport slave (
`ifdef LOADER_REUSE_B_EN
    output reuse_b,
`endif
    output in_valid,
    output in_data,
    input  in_ready,
    input  input_data_a,
    input  input_data_b,
    input  load_params,
    input  start_comp,
    input  busy,
    input  job_done
  );
endinterface

// File: rtl/sys_array_loader.sv
// Streams B then A row-major into matrix registers and sequences fetcher load/start/wait; 1-cycle state latency.
// in_ready only in LOAD_B/LOAD_A, never during reset; LOADER_REUSE_B_EN keeps B and skips PARAM on reuse_b.
module sys_array_loader #(
  parameter int DATA_WIDTH  = 8,
  parameter int ARRAY_W     = 4,
  parameter int ARRAY_L     = 4,
  parameter int HOLD_CYCLES = 2*(ARRAY_W+1),
  parameter int COMP_CYCLES = (ARRAY_L+2*ARRAY_W+3)*(ARRAY_W+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  sys_array_loader_if.master   bus
);

  localparam int MAX_CNT = (HOLD_CYCLES > COMP_CYCLES) ? HOLD_CYCLES : COMP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int ROW_W   = $clog2(ARRAY_W);
  localparam int COL_W   = $clog2(ARRAY_L);

  typedef logic [ARRAY_W-1:0][ARRAY_L-1:0][DATA_WIDTH-1:0] mat_t;

  typedef enum logic [2:0] {
    S_LOAD_B,
    S_LOAD_A,
    S_PARAM,
    S_START,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mat_t             mat_a_q, mat_a_d;
  mat_t             mat_b_q, mat_b_d;
`ifdef LOADER_REUSE_B_EN
  logic             b_loaded_q, b_loaded_d;
  logic             skip_param_q, skip_param_d;
`endif

  logic in_ready;
  logic accept;
  logic last_elem;
  logic last_col;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
`ifdef LOADER_REUSE_B_EN
    b_loaded_d   = b_loaded_q;
    skip_param_d = skip_param_q;
`endif

    // Reset cycles never present ready, so nothing can be taken while reset is high.
    in_ready  = ((state_q == S_LOAD_B) || (state_q == S_LOAD_A)) && !reset;
    accept    = bus.in_valid && in_ready;
    last_col  = (col_q == COL_W'(ARRAY_L - 1));
    last_elem = last_col && (row_q == ROW_W'(ARRAY_W - 1));

    if (accept) begin
      if (state_q == S_LOAD_B) begin
        mat_b_d[row_q][col_q] = bus.in_data;
      end else begin
        mat_a_d[row_q][col_q] = bus.in_data;
      end
      if (last_elem) begin
        row_d = '0;
        col_d = '0;
      end else if (last_col) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    case (state_q)
      S_LOAD_B: begin
        cnt_d = '0;
        if (accept && last_elem) begin
          state_d = S_LOAD_A;
`ifdef LOADER_REUSE_B_EN
          b_loaded_d   = 1'b1;
          skip_param_d = 1'b0;
`endif
        end
      end
      S_LOAD_A: begin
        cnt_d = '0;
        if (accept && last_elem) begin
          cnt_d = CNT_W'(HOLD_CYCLES - 1);
`ifdef LOADER_REUSE_B_EN
          state_d = skip_param_q ? S_START : S_PARAM;
`else
          state_d = S_PARAM;
`endif
        end
      end
      S_PARAM: begin
        if (cnt_q == '0) begin
          state_d = S_START;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(COMP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
`ifdef LOADER_REUSE_B_EN
          if (bus.reuse_b && b_loaded_q) begin
            state_d      = S_LOAD_A;
            skip_param_d = 1'b1;
          end else begin
            state_d = S_LOAD_B;
          end
`else
          state_d = S_LOAD_B;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOAD_B;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD_B;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
`ifdef LOADER_REUSE_B_EN
      b_loaded_q   <= 1'b0;
      skip_param_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
`ifdef LOADER_REUSE_B_EN
      b_loaded_q   <= b_loaded_d;
      skip_param_q <= skip_param_d;
`endif
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.input_data_a = mat_a_q;
  assign bus.input_data_b = mat_b_q;
  assign bus.load_params  = (state_q == S_PARAM);
  assign bus.start_comp   = (state_q == S_START);
  assign bus.busy         = (state_q != S_LOAD_B) && (state_q != S_LOAD_A);
  assign bus.job_done     = (state_q == S_WAIT) && (cnt_q == '0);

  // The fetcher samples on a divided clock, so the matrices must not move once handed over.
  assert property (@(posedge clk) disable iff (reset)
    !(bus.load_params && bus.start_comp));
  assert property (@(posedge clk) disable iff (reset)
    (state_q inside {S_PARAM, S_START, S_WAIT}) |=> ($stable(mat_a_q) && $stable(mat_b_q)));

endmodule

// File: tb/tb_sys_array_loader.sv
// Randomized stream jobs for sys_array_loader; a negedge monitor scores each job_done against queued expectations.
`timescale 1ns/1ps
module tb_sys_array_loader;
  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int L    = 4;
  localparam int N    = W*L;
  localparam int HOLD = 2*(W+1);
  localparam int COMP = (L+2*W+3)*(W+1);
  localparam int VW   = W*L*DW;

  typedef logic [W-1:0][L-1:0][DW-1:0] mat_t;
  typedef logic [DW-1:0] byte_q[$];
  typedef struct { mat_t a; mat_t b; bit param; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  mat_t cur_a = '0;
  mat_t cur_b = '0;

  sys_array_loader_if #(.DATA_WIDTH(DW), .ARRAY_W(W), .ARRAY_L(L)) bus();

  sys_array_loader #(.DATA_WIDTH(DW), .ARRAY_W(W), .ARRAY_L(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Element k of a stream lands at row k/L, column k%L.
  function automatic mat_t build(input byte_q v);
    mat_t m = '0;
    for (int k = 0; k < v.size(); k++) m[k/L][k%L] = v[k];
    return m;
  endfunction

  // Monitor: measures control pulse widths and latency, scores each completed job.
  int   cyc = 0, last_acc = -1000, lp_len = 0, sc_len = 0, wait_len = 0, lat = 0;
  bit   overlap = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      sb.delete();
      lp_len = 0; sc_len = 0; wait_len = 0; overlap = 0; last_acc = -1000;
    end else begin
      if (bus.load_params && bus.start_comp) overlap = 1;
      if (bus.in_valid && bus.in_ready) last_acc = cyc;
      if (bus.load_params) lp_len++;
      if (bus.start_comp) begin
        if (sc_len == 0) lat = cyc - last_acc;
        sc_len++;
      end else if (sc_len > 0) begin
        wait_len++;
      end
      if (bus.job_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_job_done", bus.job_done, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("job_mat_a", bus.input_data_a, mon_e.a);
          chk("job_mat_b", bus.input_data_b, mon_e.b);
          chk("load_params_len", lp_len, mon_e.param ? HOLD : 0);
          chk("start_comp_len", sc_len, HOLD);
          chk("wait_len", wait_len, COMP);
          chk("start_latency", lat, mon_e.param ? HOLD + 1 : 1);
          chk("lp_sc_overlap", overlap, 0);
        end
        lp_len = 0; sc_len = 0; wait_len = 0; overlap = 0;
      end
    end
  end

  task automatic send(input logic [DW-1:0] v, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (!bus.in_ready) chk("accept_wait", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic run_job(input bit with_b, input bit dir, input int gap_mode);
    byte_q bv, av;
    exp_t  e;
    for (int k = 0; k < N; k++) begin
      bv.push_back(dir ? DW'(k + 1) : DW'($urandom));
      av.push_back(dir ? DW'(N + k + 1) : DW'($urandom));
    end
    if (with_b) begin
      for (int k = 0; k < N; k++) send(bv[k], pick_gap(gap_mode));
      cur_b = build(bv);
    end
    for (int k = 0; k < N; k++) begin
      if (k == N-1) chk("busy_before_last_a", bus.busy, 0);
      send(av[k], pick_gap(gap_mode));
    end
    cur_a   = build(av);
    e.a     = cur_a;
    e.b     = cur_b;
    e.param = with_b;
    sb.push_back(e);
    @(negedge clk);
    chk("busy_after_last_a", bus.busy, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end while (bus.busy && t < 1000);
    chk("idle_wait", bus.busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset_check(input string tag);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'($urandom);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_start_comp"}, bus.start_comp, 0);
    chk({tag, "_load_params"}, bus.load_params, 0);
    chk({tag, "_job_done"}, bus.job_done, 0);
    chk({tag, "_mat_a"}, bus.input_data_a, '0);
    chk({tag, "_mat_b"}, bus.input_data_b, '0);
    cur_a = '0;
    cur_b = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cnt;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
`ifdef LOADER_REUSE_B_EN
    bus.reuse_b  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    pulse_reset_check("init");

    // Directed 1..32, continuous then every other cycle.
    run_job(1, 1, 0);
    wait_idle();
    chk("dir_b12", bus.input_data_b[1][2], 8'd7);
    chk("dir_a33", bus.input_data_a[3][3], 8'd32);
    run_job(1, 1, 1);
    wait_idle();
    chk("gap_b12", bus.input_data_b[1][2], 8'd7);
    chk("gap_a33", bus.input_data_a[3][3], 8'd32);

    // Random jobs; the second one sees in_valid hammered while busy.
    for (int j = 0; j < 3; j++) begin
      run_job(1, 0, 2);
      if (j == 1) begin
        rdy_cnt = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
          bus.in_data = DW'($urandom);
          @(negedge clk);
          if (bus.in_ready) rdy_cnt++;
          @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("ready_while_busy", rdy_cnt, 0);
      end
      wait_idle();
    end

    // Reset after 9 B elements.
    for (int k = 0; k < 9; k++) send(DW'($urandom), 0);
    pulse_reset_check("rst_midb");

    // Reset during START.
    run_job(1, 0, 2);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.start_comp) break;
    end
    chk("start_seen", bus.start_comp, 1);
    @(posedge clk); #1;
    pulse_reset_check("rst_start");

    run_job(1, 0, 2);
    wait_idle();

`ifdef LOADER_REUSE_B_EN
    pulse_reset_check("rst_reuse");
    bus.reuse_b = 1'b1;
    run_job(1, 0, 2);
    wait_idle();
    run_job(0, 0, 2);
    bus.reuse_b = 1'b0;
    wait_idle();
    chk("reuse_b_kept", bus.input_data_b, cur_b);
    run_job(1, 0, 2);
    wait_idle();
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
